idx_serializer: RTL and testbench

IDX_SERIALIZER -- requirements
Module: idx_serializer

---
 rtl/idx_pkg.sv | 18 +
 rtl/idx_serializer.sv | 156 +++++++++++++++
 tb/tb_idx_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/idx_pkg.sv
// Shared constants and types for the index serializer.
package idx_pkg;

  localparam int unsigned MAX_SLOTS = 4;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_TAG_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Slot counts above MAX_SLOTS saturate rather than wrap.
  function automatic logic [2:0] clamp_num(input logic [2:0] num);
    return (num > 3'd4) ? 3'd4 : num;
  endfunction

endpackage

// File: rtl/idx_serializer.sv
// Serializes a packed group of up to four indices into one beat per cycle.
// Optional IDX_SER_EMPTY_BEAT_EN: zero-length groups emit a single o_empty beat.
module idx_serializer
  import idx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_idx1,
  input  logic [WIDTH-1:0] i_idx2,
  input  logic [WIDTH-1:0] i_idx3,
  input  logic [WIDTH-1:0] i_idx4,
  input  logic [2:0]       i_num,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_idx,
  output logic             o_last,
`ifdef IDX_SER_EMPTY_BEAT_EN
  output logic             o_empty,
`endif
  output logic [TAG_W-1:0] o_tag
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] slot_q [MAX_SLOTS];
  logic [WIDTH-1:0] slot_d [MAX_SLOTS];
  logic [WIDTH-1:0] idx_in [MAX_SLOTS];
  logic [1:0]       ptr_q, ptr_d, ptr_nxt;
  logic [2:0]       rem_q, rem_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
  logic [TAG_W-1:0] o_tag_q, o_tag_d;
  logic [WIDTH-1:0] o_idx_q, o_idx_d;
  logic             o_valid_q, o_valid_d;
  logic             o_last_q, o_last_d;
`ifdef IDX_SER_EMPTY_BEAT_EN
  logic             o_empty_q, o_empty_d;
`endif
  logic [2:0]       num_c;
  logic             consume;
  logic             accept;

  assign idx_in[0] = i_idx1;
  assign idx_in[1] = i_idx2;
  assign idx_in[2] = i_idx3;
  assign idx_in[3] = i_idx4;

  assign num_c   = clamp_num(i_num);
  assign consume = o_valid_q && i_ready;
  assign o_ready = (state_q == IDLE) || (consume && o_last_q);
  assign accept  = i_valid && o_ready;
  assign ptr_nxt = ptr_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    tag_cnt_d = tag_cnt_q;
    o_tag_d   = o_tag_q;
    o_idx_d   = o_idx_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
`ifdef IDX_SER_EMPTY_BEAT_EN
    o_empty_d = o_empty_q;
`endif

    if (consume) begin
      if (o_last_q) begin
        state_d   = IDLE;
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
        rem_d     = '0;
`ifdef IDX_SER_EMPTY_BEAT_EN
        o_empty_d = 1'b0;
`endif
      end else begin
        ptr_d    = ptr_nxt;
        rem_d    = rem_q - 3'd1;
        o_idx_d  = slot_q[ptr_nxt];
        o_last_d = (rem_q == 3'd2);
      end
    end

    // A new group overrides the end-of-group return to IDLE, giving zero-bubble handoff.
    if (accept) begin
      tag_cnt_d = tag_cnt_q + 1'b1;
      if (num_c != 3'd0) begin
        for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
          if (i < 32'(num_c)) slot_d[i] = idx_in[i];
        end
        state_d   = EMIT;
        ptr_d     = '0;
        rem_d     = num_c;
        o_valid_d = 1'b1;
        o_idx_d   = i_idx1;
        o_last_d  = (num_c == 3'd1);
        o_tag_d   = tag_cnt_q;
`ifdef IDX_SER_EMPTY_BEAT_EN
        o_empty_d = 1'b0;
      end else begin
        state_d   = EMIT;
        ptr_d     = '0;
        rem_d     = 3'd1;
        o_valid_d = 1'b1;
        o_idx_d   = '0;
        o_last_d  = 1'b1;
        o_tag_d   = tag_cnt_q;
        o_empty_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      slot_q    <= '{default: '0};
      ptr_q     <= '0;
      rem_q     <= '0;
      tag_cnt_q <= '0;
      o_tag_q   <= '0;
      o_idx_q   <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
`ifdef IDX_SER_EMPTY_BEAT_EN
      o_empty_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      tag_cnt_q <= tag_cnt_d;
      o_tag_q   <= o_tag_d;
      o_idx_q   <= o_idx_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
`ifdef IDX_SER_EMPTY_BEAT_EN
      o_empty_q <= o_empty_d;
`endif
    end
  end

  assign o_valid = o_valid_q;
  assign o_idx   = o_idx_q;
  assign o_last  = o_last_q;
  assign o_tag   = o_tag_q;
`ifdef IDX_SER_EMPTY_BEAT_EN
  assign o_empty = o_empty_q;
`endif

endmodule

// File: tb/tb_idx_serializer.sv
// Directed self-checking bench for idx_serializer; honours IDX_SER_EMPTY_BEAT_EN.
module tb_idx_serializer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned TAG_W = 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_idx1, i_idx2, i_idx3, i_idx4;
  logic [2:0]       i_num;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_idx;
  logic             o_last;
  logic [TAG_W-1:0] o_tag;
`ifdef IDX_SER_EMPTY_BEAT_EN
  logic             o_empty;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  idx_serializer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_idx1  (i_idx1),
    .i_idx2  (i_idx2),
    .i_idx3  (i_idx3),
    .i_idx4  (i_idx4),
    .i_num   (i_num),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_idx   (o_idx),
    .o_last  (o_last),
`ifdef IDX_SER_EMPTY_BEAT_EN
    .o_empty (o_empty),
`endif
    .o_tag   (o_tag)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] idx, input logic last,
                             input logic [7:0] tg);
    check_val({tag, ".valid"}, 32'(o_valid), 32'd1);
    check_val({tag, ".idx"},   32'(o_idx),   32'(idx));
    check_val({tag, ".last"},  32'(o_last),  32'(last));
    check_val({tag, ".tag"},   32'(o_tag),   32'(tg));
`ifdef IDX_SER_EMPTY_BEAT_EN
    check_val({tag, ".empty"}, 32'(o_empty), 32'd0);
`endif
  endtask

  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic [2:0] n);
    i_valid = 1'b1;
    i_idx1 = a; i_idx2 = b; i_idx3 = c; i_idx4 = d;
    i_num = n;
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    check_val({tag, ".rst_valid"}, 32'(o_valid), 32'd0);
    check_val({tag, ".rst_last"},  32'(o_last),  32'd0);
    check_val({tag, ".rst_idx"},   32'(o_idx),   32'd0);
    check_val({tag, ".rst_tag"},   32'(o_tag),   32'd0);
    i_rst_n = 1'b1;
    check_val({tag, ".rst_ready"}, 32'(o_ready), 32'd1);
  endtask

  logic       rdy_seq [6];
  logic [3:0] exp_idx [6];

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_idx1 = '0; i_idx2 = '0; i_idx3 = '0; i_idx4 = '0; i_num = '0;

    // Single group of three
    do_reset("g3");
    offer(4'd5, 4'd2, 4'd9, 4'd0, 3'd3);
    tick(); i_valid = 1'b0;
    expect_beat("g3.b0", 4'd5, 1'b0, 8'd0);
    tick(); expect_beat("g3.b1", 4'd2, 1'b0, 8'd0);
    tick(); expect_beat("g3.b2", 4'd9, 1'b1, 8'd0);
    check_val("g3.ready_on_last", 32'(o_ready), 32'd1);
    tick(); check_val("g3.idle", 32'(o_valid), 32'd0);

    // Back-to-back groups, no bubble
    do_reset("b2b");
    offer(4'd1, 4'd2, 4'd0, 4'd0, 3'd2);
    tick();
    offer(4'd7, 4'd0, 4'd0, 4'd0, 3'd1);
    expect_beat("b2b.b0", 4'd1, 1'b0, 8'd0);
    check_val("b2b.not_ready", 32'(o_ready), 32'd0);
    tick(); expect_beat("b2b.b1", 4'd2, 1'b1, 8'd0);
    tick(); i_valid = 1'b0;
    expect_beat("b2b.b2", 4'd7, 1'b1, 8'd1);
    tick(); check_val("b2b.idle", 32'(o_valid), 32'd0);

    // Backpressure stall
    do_reset("stall");
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_idx = '{4'd4, 4'd4, 4'd4, 4'd6, 4'd8, 4'd0};
    offer(4'd3, 4'd4, 4'd6, 4'd8, 3'd4);
    tick(); i_valid = 1'b0;
    expect_beat("stall.b0", 4'd3, 1'b0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      i_ready = rdy_seq[k];
      tick();
      if (k < 5) expect_beat($sformatf("stall.c%0d", k), exp_idx[k], (k == 4), 8'd0);
      else check_val("stall.idle", 32'(o_valid), 32'd0);
    end
    i_ready = 1'b1;

    // Zero-length group followed by an over-range count
    do_reset("empty");
    offer(4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
    tick();
    offer(4'hA, 4'hB, 4'hC, 4'hD, 3'd7);
`ifdef IDX_SER_EMPTY_BEAT_EN
    check_val("empty.valid", 32'(o_valid), 32'd1);
    check_val("empty.flag",  32'(o_empty), 32'd1);
    check_val("empty.last",  32'(o_last),  32'd1);
    check_val("empty.idx",   32'(o_idx),   32'd0);
    check_val("empty.tag",   32'(o_tag),   32'd0);
    tick();
`else
    check_val("empty.no_beat", 32'(o_valid), 32'd0);
    check_val("empty.ready",   32'(o_ready), 32'd1);
    tick();
`endif
    i_valid = 1'b0;
    expect_beat("empty.bA", 4'hA, 1'b0, 8'd1);
    tick(); expect_beat("empty.bB", 4'hB, 1'b0, 8'd1);
    tick(); expect_beat("empty.bC", 4'hC, 1'b0, 8'd1);
    tick(); expect_beat("empty.bD", 4'hD, 1'b1, 8'd1);
    tick(); check_val("empty.idle", 32'(o_valid), 32'd0);

    // Reset mid-group discards the remaining beats
    do_reset("midrst");
    offer(4'd1, 4'd2, 4'd3, 4'd4, 3'd4);
    tick(); i_valid = 1'b0;
    expect_beat("midrst.b0", 4'd1, 1'b0, 8'd0);
    tick(); expect_beat("midrst.b1", 4'd2, 1'b0, 8'd0);
    tick(); expect_beat("midrst.b2", 4'd3, 1'b0, 8'd0);
    i_rst_n = 1'b0;
    tick();
    check_val("midrst.valid", 32'(o_valid), 32'd0);
    check_val("midrst.last",  32'(o_last),  32'd0);
    check_val("midrst.tag",   32'(o_tag),   32'd0);
    i_rst_n = 1'b1;
    offer(4'd5, 4'd6, 4'd0, 4'd0, 3'd2);
    check_val("midrst.ready", 32'(o_ready), 32'd1);
    tick(); i_valid = 1'b0;
    expect_beat("midrst.n0", 4'd5, 1'b0, 8'd0);
    tick(); expect_beat("midrst.n1", 4'd6, 1'b1, 8'd0);
    tick(); check_val("midrst.idle", 32'(o_valid), 32'd0);

    // Tag wrap over 300 single-index groups
    do_reset("wrap");
    for (int k = 0; k < 300; k++) begin
      offer(4'(k), 4'd0, 4'd0, 4'd0, 3'd1);
      tick();
      check_val($sformatf("wrap.tag%0d", k), 32'(o_tag), 32'(k % 256));
      if (k >= 254 && k <= 257) expect_beat($sformatf("wrap.beat%0d", k), 4'(k), 1'b1, 8'(k % 256));
    end
    i_valid = 1'b0;
    tick(); check_val("wrap.idle", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
